// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the RAM port arbiter, its two requesters (CPU, front panel) and the RAM.
// slave = arbiter side, master = requester/RAM side.
interface ram_port_arbiter_if #(
   parameter int unsigned AW = 16,
   parameter int unsigned DW = 8
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_done;
   logic [DW-1:0] cpu_rdata;

   logic          pnl_req;
   logic          pnl_we;
   logic [AW-1:0] pnl_addr;
   logic [DW-1:0] pnl_wdata;
   logic          pnl_done;
   logic [DW-1:0] pnl_rdata;
   logic          pnl_lock;

   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_read;
   logic          ram_write;
   logic [DW-1:0] ram_rdata;

   logic          busy;
   logic          owner;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_done, cpu_rdata,
      input  pnl_req, pnl_we, pnl_addr, pnl_wdata, pnl_lock,
      output pnl_done, pnl_rdata,
      output ram_addr, ram_wdata, ram_read, ram_write,
      input  ram_rdata,
      output busy, owner
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_done, cpu_rdata,
      output pnl_req, pnl_we, pnl_addr, pnl_wdata, pnl_lock,
      input  pnl_done, pnl_rdata,
      input  ram_addr, ram_wdata, ram_read, ram_write,
      output ram_rdata,
      input  busy, owner
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the CPU and the front-panel loader.
// Optional macro ARB_LOCK_EN: while pnl_lock is high the CPU is excluded from arbitration.
module ram_port_arbiter #(
   parameter int unsigned AW      = 16,
   parameter int unsigned DW      = 8,
   parameter int unsigned ACC_CYC = 2
) (
   input logic               clk,
   input logic               rst,
   ram_port_arbiter_if.slave bus
);
   localparam int unsigned   CW       = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(ACC_CYC - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          last_owner;
   logic          own;
   logic          we_l;
   logic [AW-1:0] addr_l;
   logic [DW-1:0] wdata_l;

   logic          cpu_cand;
   logic          grant_any;
   logic          grant_pnl;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

`ifdef ARB_LOCK_EN
   always_comb cpu_cand = bus.cpu_req & ~bus.pnl_lock;
`else
   logic unused_lock;
   assign unused_lock = bus.pnl_lock;
   always_comb cpu_cand = bus.cpu_req;
`endif

   // Panel wins when it is the only candidate or when the CPU had the previous grant.
   always_comb begin
      grant_any = cpu_cand | bus.pnl_req;
      grant_pnl = bus.pnl_req & (~cpu_cand | ~last_owner);
      sel_we    = grant_pnl ? bus.pnl_we    : bus.cpu_we;
      sel_addr  = grant_pnl ? bus.pnl_addr  : bus.cpu_addr;
      sel_wdata = grant_pnl ? bus.pnl_wdata : bus.cpu_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         last_owner    <= 1'b1;
         own           <= 1'b0;
         we_l          <= 1'b0;
         addr_l        <= '0;
         wdata_l       <= '0;
         bus.ram_read  <= 1'b0;
         bus.ram_write <= 1'b0;
         bus.cpu_done  <= 1'b0;
         bus.pnl_done  <= 1'b0;
         bus.cpu_rdata <= '0;
         bus.pnl_rdata <= '0;
      end else begin
         bus.cpu_done <= 1'b0;
         bus.pnl_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_any) begin
                  own           <= grant_pnl;
                  we_l          <= sel_we;
                  addr_l        <= sel_addr;
                  wdata_l       <= sel_wdata;
                  cnt           <= CNT_LOAD;
                  bus.ram_read  <= ~sel_we;
                  bus.ram_write <= sel_we;
                  state         <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (cnt == '0) begin
                  if (!we_l) begin
                     if (own) bus.pnl_rdata <= bus.ram_rdata;
                     else     bus.cpu_rdata <= bus.ram_rdata;
                  end
                  bus.ram_read  <= 1'b0;
                  bus.ram_write <= 1'b0;
                  bus.cpu_done  <= ~own;
                  bus.pnl_done  <= own;
                  state         <= ST_DONE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_DONE: begin
               last_owner <= own;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.ram_addr  = addr_l;
   assign bus.ram_wdata = wdata_l;
   assign bus.owner     = own;
   assign bus.busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: transaction-level round-robin model plus RAM model.
// Build with ARB_LOCK_EN defined to exercise the panel lock feature as well.
module tb_ram_port_arbiter;
   localparam int unsigned AW      = 16;
   localparam int unsigned DW      = 8;
   localparam int unsigned ACC_CYC = 2;
`ifdef ARB_LOCK_EN
   localparam bit LOCK_ON = 1'b1;
`else
   localparam bit LOCK_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   ram_port_arbiter #(.AW(AW), .DW(DW), .ACC_CYC(ACC_CYC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // RAM behind the arbiter
   logic [DW-1:0] mem [0:65535];
   initial for (int i = 0; i < 65536; i++) mem[i] <= '0;
   always @(posedge clk) if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_wdata;
   assign bus.ram_rdata = mem[bus.ram_addr];

   typedef struct {
      bit            who;
      bit            we;
      logic [DW-1:0] rdata;
      int unsigned   done_cyc;
   } exp_t;

   exp_t          sb[$];
   bit            done_log[$];
   int unsigned   done_cyc_log[$];
   logic [DW-1:0] ref_mem [0:65535];

   int unsigned   total = 0;
   int unsigned   bad = 0;
   int unsigned   cyc = 0;
   int unsigned   free_at = 0;
   bit            last_pnl = 1'b1;
   bit            exp_owner = 1'b0;
   bit            act_valid = 1'b0;
   int unsigned   act_g = 0;
   bit            act_who = 1'b0;
   bit            act_we = 1'b0;
   logic [AW-1:0] act_addr = '0;
   logic [DW-1:0] act_wdata = '0;
   logic [DW-1:0] act_rdata = '0;
   logic [DW-1:0] held_c = '0;
   logic [DW-1:0] held_p = '0;
   bit            rand_stop = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom);
      return AW'($urandom_range(0, 15));
   endfunction

   // Reference model: one access at a time, each occupying ACC_CYC+2 cycles, fields taken at grant.
   initial begin
      bit c, p, w;
      logic [DW-1:0] rd;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst) begin
            last_pnl  = 1'b1;
            exp_owner = 1'b0;
            act_valid = 1'b0;
            free_at   = 0;
            sb.delete();
         end else if (cyc >= free_at) begin
            c = bus.cpu_req && !(LOCK_ON && bus.pnl_lock);
            p = bus.pnl_req;
            if (c || p) begin
               if (c && p) w = !last_pnl;
               else        w = p;
               act_valid = 1'b1;
               act_g     = cyc;
               act_who   = w;
               act_we    = w ? bus.pnl_we    : bus.cpu_we;
               act_addr  = w ? bus.pnl_addr  : bus.cpu_addr;
               act_wdata = w ? bus.pnl_wdata : bus.cpu_wdata;
               rd = '0;
               if (act_we) ref_mem[act_addr] = act_wdata;
               else        rd = ref_mem[act_addr];
               act_rdata = rd;
               sb.push_back('{who: w, we: act_we, rdata: rd, done_cyc: cyc + ACC_CYC});
               free_at   = cyc + ACC_CYC + 2;
               last_pnl  = w;
               exp_owner = w;
            end
         end
      end
   end

   // Monitor: per-cycle output expectations and scoreboard pop on every done pulse.
   initial begin
      bit in_acc, in_done;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("reset_outputs", 32'({bus.ram_read, bus.ram_write, bus.busy, bus.owner,
                bus.cpu_done, bus.pnl_done, bus.cpu_rdata, bus.pnl_rdata}), 32'd0);
            held_c = '0;
            held_p = '0;
         end else begin
            in_acc  = act_valid && (cyc >= act_g) && (cyc < act_g + ACC_CYC);
            in_done = act_valid && (cyc == act_g + ACC_CYC);
            chk("ram_read", 32'(bus.ram_read), 32'(in_acc && !act_we));
            chk("ram_write", 32'(bus.ram_write), 32'(in_acc && act_we));
            if (in_acc) begin
               chk("ram_addr", 32'(bus.ram_addr), 32'(act_addr));
               chk("ram_wdata", 32'(bus.ram_wdata), 32'(act_wdata));
            end
            chk("busy", 32'(bus.busy), 32'(in_acc || in_done));
            chk("owner", 32'(bus.owner), 32'(exp_owner));
            chk("done_bits", 32'({bus.cpu_done, bus.pnl_done}),
                32'(in_done ? (act_who ? 2'b01 : 2'b10) : 2'b00));
            if (in_done && !act_we) begin
               if (act_who) held_p = act_rdata;
               else         held_c = act_rdata;
            end
            if (bus.cpu_done || bus.pnl_done) begin
               done_log.push_back(bus.pnl_done);
               done_cyc_log.push_back(cyc);
               chk("sb_entry_present", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk("done_who", 32'(bus.pnl_done), 32'(e.who));
                  chk("done_cycle", cyc, e.done_cyc);
                  if (!e.we)
                     chk("done_rdata", 32'(e.who ? bus.pnl_rdata : bus.cpu_rdata), 32'(e.rdata));
               end
            end
            chk("cpu_rdata_hold", 32'(bus.cpu_rdata), 32'(held_c));
            chk("pnl_rdata_hold", 32'(bus.pnl_rdata), 32'(held_p));
         end
      end
   end

   task automatic drive(input bit who, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit r);
      if (who) begin
         bus.pnl_we = we; bus.pnl_addr = a; bus.pnl_wdata = d; bus.pnl_req = r;
      end else begin
         bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_req = r;
      end
   endtask

   task automatic set_req(input bit who, input bit r);
      if (who) bus.pnl_req = r;
      else     bus.cpu_req = r;
   endtask

   // One requester transaction; called #1 after a rising edge, returns #1 after the edge ending done.
   task automatic xact(input bit who, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit scramble, input bit keep);
      int unsigned n;
      bit seen;
      n = 0;
      seen = 1'b0;
      drive(who, we, a, d, 1'b1);
      while (!seen && n < 2000) begin
         @(negedge clk);
         seen = who ? bus.pnl_done : bus.cpu_done;
         n++;
         @(posedge clk);
         #1;
         if (!seen && scramble && $urandom_range(0, 3) == 0)
            drive(who, 1'($urandom), rnd_addr(), DW'($urandom), 1'b1);
      end
      chk(who ? "pnl_done_seen" : "cpu_done_seen", 32'(seen), 32'd1);
      if (!keep) set_req(who, 1'b0);
   endtask

   task automatic requester(input bit who, input int unsigned cnt);
      int unsigned nxt;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      for (int unsigned i = 0; i < cnt; i++) begin
         nxt = $urandom_range(0, 3);
         xact(who, 1'($urandom), rnd_addr(), DW'($urandom), 1'b1, (nxt == 0) && (i + 1 < cnt));
         repeat (nxt) begin @(posedge clk); #1; end
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      int unsigned n;
      for (int i = 0; i < 65536; i++) ref_mem[i] = '0;
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      bus.pnl_lock = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // panel write then CPU read-back
      xact(1'b1, 1'b1, 16'h0010, 8'hA5, 1'b0, 1'b0);
      chk("t1_ram_content", 32'(mem[16'h0010]), 32'h0000_00A5);
      repeat (2) begin @(posedge clk); #1; end
      xact(1'b0, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0);
      chk("t2_cpu_rdata", 32'(bus.cpu_rdata), 32'h0000_00A5);

      // simultaneous requests straight out of reset: CPU first
      do_reset();
      done_log.delete();
      fork
         xact(1'b0, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0);
         xact(1'b1, 1'b1, 16'h0011, 8'h3C, 1'b0, 1'b0);
      join
      chk("t3_first_cpu", 32'(done_log[0]), 32'd0);
      chk("t3_second_pnl", 32'(done_log[1]), 32'd1);

      // CPU holds request continuously against a back-to-back panel
      done_log.delete();
      done_cyc_log.delete();
      fork
         begin
            xact(1'b0, 1'b1, 16'h0100, 8'h11, 1'b0, 1'b1);
            xact(1'b0, 1'b0, 16'h0100, 8'h00, 1'b0, 1'b1);
            xact(1'b0, 1'b1, 16'h0101, 8'h33, 1'b0, 1'b0);
         end
         begin
            xact(1'b1, 1'b0, 16'h0100, 8'h00, 1'b0, 1'b1);
            xact(1'b1, 1'b1, 16'h0102, 8'h44, 1'b0, 1'b0);
         end
      join
      chk("t4_count", 32'(done_log.size()), 32'd5);
      for (int i = 0; i < 5; i++) chk("t4_order", 32'(done_log[i]), 32'(i % 2));
      for (int i = 1; i < 5; i++)
         chk("t4_spacing", done_cyc_log[i] - done_cyc_log[i-1], ACC_CYC + 2);

`ifdef ARB_LOCK_EN
      // lock: only the panel is eligible until lock drops
      do_reset();
      done_log.delete();
      bus.pnl_lock = 1'b1;
      fork
         xact(1'b0, 1'b0, 16'h0102, 8'h00, 1'b0, 1'b0);
         begin
            xact(1'b1, 1'b1, 16'h0020, 8'h5A, 1'b0, 1'b0);
            repeat (6) begin @(posedge clk); #1; chk("t6_cpu_blocked", 32'(bus.busy), 32'd0); end
            bus.pnl_lock = 1'b0;
         end
      join
      chk("t6_first_pnl", 32'(done_log[0]), 32'd1);
      chk("t6_then_cpu", 32'(done_log[1]), 32'd0);
`endif

      // randomized contention, lock toggling (ignored unless ARB_LOCK_EN)
      fork
         begin
            fork
               requester(1'b0, 40);
               requester(1'b1, 40);
            join
            rand_stop = 1'b1;
         end
         begin
            while (!rand_stop) begin
               @(posedge clk); #1;
               if ($urandom_range(0, 7) == 0) bus.pnl_lock = ($urandom_range(0, 3) == 0);
            end
            bus.pnl_lock = 1'b0;
         end
      join

      // async reset in the middle of a read access
      repeat (3) begin @(posedge clk); #1; end
      done_log.delete();
      drive(1'b1, 1'b0, 16'h0010, 8'h00, 1'b1);
      n = 0;
      while (!bus.ram_read && n < 20) begin @(negedge clk); n++; end
      chk("t5_reached_access", 32'(bus.ram_read), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("t5_strobes_drop", 32'({bus.ram_read, bus.ram_write}), 32'd0);
      chk("t5_idle", 32'(bus.busy), 32'd0);
      set_req(1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (8) begin @(posedge clk); #1; end
      chk("t5_no_done", 32'(done_log.size()), 32'd0);

      repeat (4) begin @(posedge clk); #1; end
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
